lsf_input_buffer: RTL and testbench
===================================

Name: lsf_input_buffer

Overview:
- Upstream feeder for the Legendre segment-finder engine.
- Accepts the HPS MDT hit stream and slice-processor ROI words through valid/ready handshakes, and frames hits into events, one event per ROI.
- Buffers hits and ROIs in first-word-fall-through FIFOs and exposes them through the engine's read-enable/empty interface.
- Pairs each committed ROI with that event's hit count, which drives the engine's histogram_accumulation_count.

Parameters:
HIT_W, HPS_LSF_LEN, width of one MDT hit word
ROI_W, SLCPROC_HPS_SF_LEN, width of one ROI word
HIT_DEPTH, 64, hit FIFO depth (power of 2)
ROI_DEPTH, 4, ROI/count FIFO depth (power of 2)
CNT_W, 10, hit-count width; saturates at 2^CNT_W-1

Ports:
clk  in  1  single clock
rst  in  1  asynchronous active-low reset
srst  in  1  synchronous active-high flush
hit_i  in  HIT_W  MDT hit from HPS
hit_vld_i  in  1  hit valid
hit_ready_o  out  1  hit accepted when vld&ready
roi_i  in  ROI_W  ROI word
roi_vld_i  in  1  ROI valid
roi_ready_o  out  1  ROI accepted when vld&ready
evt_close_i  in  1  single-cycle pulse closing the open event
mdt_hit_o  out  HIT_W  head of hit FIFO
mdt_hit_empty_o  out  1  hit FIFO empty
mdt_hit_re_i  in  1  pop hit (engine read enable)
roi_o  out  ROI_W  head of committed-ROI FIFO
roi_empty_o  out  1  no committed ROI
roi_re_i  in  1  pop ROI and its count
histogram_accumulation_count_o  out  CNT_W  hit count of ROI at head
drop_cnt_o  out  16  hits dropped (saturating at 0xFFFF)
cnt_sat_o  out  1  sticky: an event count saturated

Behaviour:
- Reset values (rst=0, or srst=1 at a clock edge):
  - state=IDLE, both FIFOs empty, both empties=1, both readies=0.
  - Data outputs 0, histogram_accumulation_count_o=0, drop_cnt_o=0, cnt_sat_o=0.
- srst has the same effect as rst, applied synchronously; it aborts any open event and discards its ROI and count.
- FSM IDLE:
  - roi_ready_o is registered = ROI FIFO not full (including uncommitted slot). It asserts on the first clock after reset release.
  - On roi_vld_i&roi_ready_o: write the ROI to an uncommitted slot, clear the event counter, go to OPEN.
  - Hits arriving in IDLE are dropped (hit_ready_o=0) and drop_cnt_o increments once per hit_vld_i cycle.
  - evt_close_i in IDLE is ignored.
- FSM OPEN:
  - roi_ready_o=0.
  - hit_ready_o = !hit_full (combinational). It is always 0 in IDLE.
  - Each accepted hit is written to the hit FIFO and increments the event counter, saturating at 2^CNT_W-1. Hits beyond the saturation point are still stored, and cnt_sat_o is set.
  - On evt_close_i:
    - A hit accepted in the same cycle belongs to the closing event.
    - The final count is written to the count FIFO, the ROI slot is committed, and the FSM returns to IDLE.
  - Zero-hit events are legal (count=0).
- Latency:
  - A hit accepted at edge N is visible (mdt_hit_empty_o=0) after edge N+1.
  - A closed event's ROI and count are visible after the edge following the close edge.
  - An ROI is never visible before its event closes.
- Reads:
  - mdt_hit_re_i / roi_re_i while the corresponding empty=1 are ignored, with no pointer movement.
  - roi_re_i pops the ROI and the count together.
  - Simultaneous write and read on a non-full FIFO: occupancy unchanged, head advances.
- Pointers carry an extra wrap bit. Full = addresses equal and wrap bits differ. Empty = pointers equal.
- The hit FIFO and the event framing are independent: the engine consumes exactly count hits per ROI. The block performs no cross-check.

Test Plan:
- Reset: hold rst=0 for 5 cycles with vld inputs high -> all outputs at reset values; roi_ready_o=1 on the 1st cycle after release; no writes occur.
- Basic event: ROI A, 3 hits, then close -> roi_empty_o falls 1 cycle after close; roi_o=A; count=3; three hits pop in order via mdt_hit_re_i.
- Close coincident with 2nd hit: ROI B, hit, then hit+close in the same cycle -> count=2; ROI C, then immediate close -> count=0; popping B then C gives counts 2 then 0.
- Backpressure: fill HIT_DEPTH=64 hits with no reads -> hit_ready_o=0 at 64; 65th hit held upstream, not lost; 1 read -> accepted the next cycle; drop_cnt_o stays 0.
- Drops and saturation: 4 hits in IDLE -> drop_cnt_o=4; event with 1030 hits (reading continuously) -> count=1023, cnt_sat_o=1, all 1030 hits readable.
- Mid-event flush: srst pulse after ROI D plus 5 hits -> all FIFOs empty, state IDLE, ROI D never appears; the next ROI E with 1 hit yields count=1.

Source files
------------

// File: rtl/lsf_input_buffer.sv
`default_nettype none
// =============================================================================
// Module   : lsf_input_buffer
// Brief    : Frames HPS MDT hits into ROI events and buffers hits, ROIs and
//            per-event hit counts in FWFT FIFOs for the Legendre segment finder.
// Revision : 1.0 - initial release
// =============================================================================
module lsf_input_buffer #(
   parameter int HIT_W     = 40,
   parameter int ROI_W     = 32,
   parameter int HIT_DEPTH = 64,
   parameter int ROI_DEPTH = 4,
   parameter int CNT_W     = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             srst,
   input  logic [HIT_W-1:0] hit_i,
   input  logic             hit_vld_i,
   output logic             hit_ready_o,
   input  logic [ROI_W-1:0] roi_i,
   input  logic             roi_vld_i,
   output logic             roi_ready_o,
   input  logic             evt_close_i,
   output logic [HIT_W-1:0] mdt_hit_o,
   output logic             mdt_hit_empty_o,
   input  logic             mdt_hit_re_i,
   output logic [ROI_W-1:0] roi_o,
   output logic             roi_empty_o,
   input  logic             roi_re_i,
   output logic [CNT_W-1:0] histogram_accumulation_count_o,
   output logic [15:0]      drop_cnt_o,
   output logic             cnt_sat_o
);

   localparam int              c_HAW     = $clog2(HIT_DEPTH);
   localparam int              c_RAW     = $clog2(ROI_DEPTH);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [c_RAW:0]  c_RFULL   = {1'b1, {c_RAW{1'b0}}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OPEN = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [c_HAW:0]     hit_wp_q, hit_wp_d, hit_rp_q, hit_rp_d;
   logic [c_RAW:0]     roi_wp_q, roi_wp_d, roi_rp_q, roi_rp_d;
   logic               hit_empty_q, roi_empty_q;
   logic               roi_ready_q, roi_ready_d;
   logic [CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
   logic               cnt_sat_q, cnt_sat_d;
   logic [15:0]        drop_q, drop_d;

   logic [HIT_W-1:0]   hit_mem [HIT_DEPTH];
   logic [ROI_W-1:0]   roi_mem [ROI_DEPTH];
   logic [CNT_W-1:0]   cnt_mem [ROI_DEPTH];

   logic               w_hit_full, w_hit_wr, w_hit_rd;
   logic               w_roi_wr, w_roi_commit, w_roi_rd;

   assign w_hit_full = (hit_wp_q[c_HAW] != hit_rp_q[c_HAW]) &&
                       (hit_wp_q[c_HAW-1:0] == hit_rp_q[c_HAW-1:0]);
   assign w_hit_rd   = mdt_hit_re_i && !hit_empty_q;
   assign w_roi_rd   = roi_re_i && !roi_empty_q;

   always_comb begin
      state_d      = state_q;
      evt_cnt_d    = evt_cnt_q;
      cnt_sat_d    = cnt_sat_q;
      drop_d       = drop_q;
      w_hit_wr     = 1'b0;
      w_roi_wr     = 1'b0;
      w_roi_commit = 1'b0;
      hit_ready_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit_vld_i && (drop_q != 16'hFFFF)) begin
               drop_d = drop_q + 16'd1;
            end
            if (roi_vld_i && roi_ready_q) begin
               w_roi_wr  = 1'b1;
               evt_cnt_d = '0;
               state_d   = ST_OPEN;
            end
         end
         ST_OPEN: begin
            hit_ready_o = !w_hit_full;
            w_hit_wr    = hit_vld_i && !w_hit_full;
            if (w_hit_wr) begin
               if (evt_cnt_q == c_CNT_MAX) begin
                  cnt_sat_d = 1'b1;
               end else begin
                  evt_cnt_d = evt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            // A hit accepted alongside the close is already folded into evt_cnt_d
            if (evt_close_i) begin
               w_roi_commit = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hit_wp_d = hit_wp_q + {{c_HAW{1'b0}}, w_hit_wr};
      hit_rp_d = hit_rp_q + {{c_HAW{1'b0}}, w_hit_rd};
      roi_wp_d = roi_wp_q + {{c_RAW{1'b0}}, w_roi_commit};
      roi_rp_d = roi_rp_q + {{c_RAW{1'b0}}, w_roi_rd};
      // Only offered in IDLE, where no uncommitted slot is held
      roi_ready_d = (state_d == ST_IDLE) && ((roi_wp_d ^ roi_rp_d) != c_RFULL);
   end

   // Empty flags use the pre-write write pointer: writes show up one edge late,
   // pops take effect immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         hit_wp_q    <= '0;
         hit_rp_q    <= '0;
         roi_wp_q    <= '0;
         roi_rp_q    <= '0;
         hit_empty_q <= 1'b1;
         roi_empty_q <= 1'b1;
         roi_ready_q <= 1'b0;
         evt_cnt_q   <= '0;
         cnt_sat_q   <= 1'b0;
         drop_q      <= '0;
      end else if (srst) begin
         state_q     <= ST_IDLE;
         hit_wp_q    <= '0;
         hit_rp_q    <= '0;
         roi_wp_q    <= '0;
         roi_rp_q    <= '0;
         hit_empty_q <= 1'b1;
         roi_empty_q <= 1'b1;
         roi_ready_q <= 1'b0;
         evt_cnt_q   <= '0;
         cnt_sat_q   <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         hit_wp_q    <= hit_wp_d;
         hit_rp_q    <= hit_rp_d;
         roi_wp_q    <= roi_wp_d;
         roi_rp_q    <= roi_rp_d;
         hit_empty_q <= (hit_wp_q == hit_rp_d);
         roi_empty_q <= (roi_wp_q == roi_rp_d);
         roi_ready_q <= roi_ready_d;
         evt_cnt_q   <= evt_cnt_d;
         cnt_sat_q   <= cnt_sat_d;
         drop_q      <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_hit_wr) begin
         hit_mem[hit_wp_q[c_HAW-1:0]] <= hit_i;
      end
      if (w_roi_wr) begin
         roi_mem[roi_wp_q[c_RAW-1:0]] <= roi_i;
      end
      if (w_roi_commit) begin
         cnt_mem[roi_wp_q[c_RAW-1:0]] <= evt_cnt_d;
      end
   end

   assign roi_ready_o                    = roi_ready_q;
   assign mdt_hit_empty_o                = hit_empty_q;
   assign roi_empty_o                    = roi_empty_q;
   assign mdt_hit_o                      = hit_empty_q ? '0 : hit_mem[hit_rp_q[c_HAW-1:0]];
   assign roi_o                          = roi_empty_q ? '0 : roi_mem[roi_rp_q[c_RAW-1:0]];
   assign histogram_accumulation_count_o = roi_empty_q ? '0 : cnt_mem[roi_rp_q[c_RAW-1:0]];
   assign drop_cnt_o                     = drop_q;
   assign cnt_sat_o                      = cnt_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_lsf_input_buffer.sv
`default_nettype none
// =============================================================================
// Module   : tb_lsf_input_buffer
// Brief    : Directed self-checking bench for lsf_input_buffer.
// Revision : 1.0 - initial release
// =============================================================================
module tb_lsf_input_buffer;

   localparam int HIT_W     = 40;
   localparam int ROI_W     = 32;
   localparam int HIT_DEPTH = 64;
   localparam int ROI_DEPTH = 4;
   localparam int CNT_W     = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             srst = 1'b0;
   logic [HIT_W-1:0] hit_i = '0;
   logic             hit_vld_i = 1'b0;
   logic             hit_ready_o;
   logic [ROI_W-1:0] roi_i = '0;
   logic             roi_vld_i = 1'b0;
   logic             roi_ready_o;
   logic             evt_close_i = 1'b0;
   logic [HIT_W-1:0] mdt_hit_o;
   logic             mdt_hit_empty_o;
   logic             mdt_hit_re_i = 1'b0;
   logic [ROI_W-1:0] roi_o;
   logic             roi_empty_o;
   logic             roi_re_i = 1'b0;
   logic [CNT_W-1:0] histogram_accumulation_count_o;
   logic [15:0]      drop_cnt_o;
   logic             cnt_sat_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lsf_input_buffer #(
      .HIT_W(HIT_W), .ROI_W(ROI_W), .HIT_DEPTH(HIT_DEPTH),
      .ROI_DEPTH(ROI_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .srst(srst),
      .hit_i(hit_i), .hit_vld_i(hit_vld_i), .hit_ready_o(hit_ready_o),
      .roi_i(roi_i), .roi_vld_i(roi_vld_i), .roi_ready_o(roi_ready_o),
      .evt_close_i(evt_close_i),
      .mdt_hit_o(mdt_hit_o), .mdt_hit_empty_o(mdt_hit_empty_o), .mdt_hit_re_i(mdt_hit_re_i),
      .roi_o(roi_o), .roi_empty_o(roi_empty_o), .roi_re_i(roi_re_i),
      .histogram_accumulation_count_o(histogram_accumulation_count_o),
      .drop_cnt_o(drop_cnt_o), .cnt_sat_o(cnt_sat_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_roi(input logic [ROI_W-1:0] v);
      int t = 0;
      roi_i     = v;
      roi_vld_i = 1'b1;
      while (!roi_ready_o && t < 50) begin
         step();
         t++;
      end
      n_checks++;
      if (roi_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL roi_handshake_timeout: roi_ready_o=%0b required 1", roi_ready_o);
      end
      step();
      roi_vld_i = 1'b0;
   endtask

   task automatic send_hit(input logic [HIT_W-1:0] v, input logic close);
      int t = 0;
      hit_i     = v;
      hit_vld_i = 1'b1;
      while (!hit_ready_o && t < 200) begin
         step();
         t++;
      end
      n_checks++;
      if (hit_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL hit_handshake_timeout: hit_ready_o=%0b required 1", hit_ready_o);
      end
      evt_close_i = close;
      step();
      hit_vld_i   = 1'b0;
      evt_close_i = 1'b0;
   endtask

   task automatic close_evt();
      evt_close_i = 1'b1;
      step();
      evt_close_i = 1'b0;
   endtask

   task automatic pop_hit();
      mdt_hit_re_i = 1'b1;
      step();
      mdt_hit_re_i = 1'b0;
   endtask

   task automatic pop_roi();
      roi_re_i = 1'b1;
      step();
      roi_re_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; hit_vld_i = 1'b1; roi_vld_i = 1'b1; evt_close_i = 1'b1;
      mdt_hit_re_i = 1'b1; roi_re_i = 1'b1; hit_i = '1; roi_i = '1;
      repeat (5) step();
      n_checks++;
      if ({hit_ready_o, roi_ready_o, mdt_hit_empty_o, roi_empty_o} !== 4'b0011) begin
         n_fail++;
         $display("FAIL reset_flags: {hrdy,rrdy,hemp,remp}=%b required 0011",
                  {hit_ready_o, roi_ready_o, mdt_hit_empty_o, roi_empty_o});
      end
      n_checks++;
      if (mdt_hit_o !== '0 || roi_o !== '0 || histogram_accumulation_count_o !== '0) begin
         n_fail++;
         $display("FAIL reset_data: hit=%h roi=%h cnt=%0d required 0", mdt_hit_o, roi_o,
                  histogram_accumulation_count_o);
      end
      n_checks++;
      if (drop_cnt_o !== 16'd0 || cnt_sat_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stats: drop=%0d sat=%0b required 0/0", drop_cnt_o, cnt_sat_o);
      end
      hit_vld_i = 1'b0; roi_vld_i = 1'b0; evt_close_i = 1'b0;
      mdt_hit_re_i = 1'b0; roi_re_i = 1'b0; hit_i = '0; roi_i = '0;
      rst = 1'b1;
      step();
      n_checks++;
      if (roi_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_roi_ready: got %0b required 1", roi_ready_o);
      end
      // Reads on empty FIFOs must be ignored
      mdt_hit_re_i = 1'b1; roi_re_i = 1'b1;
      step();
      mdt_hit_re_i = 1'b0; roi_re_i = 1'b0;
      n_checks++;
      if (mdt_hit_empty_o !== 1'b1 || roi_empty_o !== 1'b1 || drop_cnt_o !== 16'd0) begin
         n_fail++;
         $display("FAIL empty_read_ignored: hemp=%0b remp=%0b drop=%0d required 1/1/0",
                  mdt_hit_empty_o, roi_empty_o, drop_cnt_o);
      end
   endtask

   task automatic test_basic_event();
      logic [HIT_W-1:0] h [3];
      h[0] = 40'h11_0000_0001; h[1] = 40'h22_0000_0002; h[2] = 40'h33_0000_0003;
      send_roi(32'hA000_000A);
      send_hit(h[0], 1'b0);
      n_checks++;
      if (mdt_hit_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_hit_latency_early: hemp=%0b required 1", mdt_hit_empty_o);
      end
      send_hit(h[1], 1'b0);
      n_checks++;
      if (mdt_hit_empty_o !== 1'b0 || mdt_hit_o !== h[0]) begin
         n_fail++;
         $display("FAIL basic_hit_visible: hemp=%0b head=%h required 0/%h", mdt_hit_empty_o,
                  mdt_hit_o, h[0]);
      end
      send_hit(h[2], 1'b0);
      close_evt();
      n_checks++;
      if (roi_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_roi_early: roi_empty_o=%0b required 1", roi_empty_o);
      end
      step();
      n_checks++;
      if (roi_empty_o !== 1'b0 || roi_o !== 32'hA000_000A || histogram_accumulation_count_o !== 10'd3) begin
         n_fail++;
         $display("FAIL basic_roi: empty=%0b roi=%h cnt=%0d required 0/a000000a/3", roi_empty_o,
                  roi_o, histogram_accumulation_count_o);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (mdt_hit_o !== h[i]) begin
            n_fail++;
            $display("FAIL basic_hit_order[%0d]: got %h required %h", i, mdt_hit_o, h[i]);
         end
         pop_hit();
      end
      pop_roi();
      n_checks++;
      if (mdt_hit_empty_o !== 1'b1 || roi_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_drained: hemp=%0b remp=%0b required 1/1", mdt_hit_empty_o, roi_empty_o);
      end
   endtask

   task automatic test_close_coincident();
      send_roi(32'h0000_000B);
      send_hit(40'hB1, 1'b0);
      send_hit(40'hB2, 1'b1);
      send_roi(32'h0000_000C);
      close_evt();
      step();
      n_checks++;
      if (roi_o !== 32'h0000_000B || histogram_accumulation_count_o !== 10'd2) begin
         n_fail++;
         $display("FAIL coincident_roi_b: roi=%h cnt=%0d required b/2", roi_o,
                  histogram_accumulation_count_o);
      end
      pop_roi();
      n_checks++;
      if (roi_empty_o !== 1'b0 || roi_o !== 32'h0000_000C || histogram_accumulation_count_o !== 10'd0) begin
         n_fail++;
         $display("FAIL coincident_roi_c: empty=%0b roi=%h cnt=%0d required 0/c/0", roi_empty_o,
                  roi_o, histogram_accumulation_count_o);
      end
      pop_roi();
      n_checks++;
      if (mdt_hit_o !== 40'hB1) begin
         n_fail++;
         $display("FAIL coincident_hit0: got %h required b1", mdt_hit_o);
      end
      pop_hit();
      n_checks++;
      if (mdt_hit_o !== 40'hB2) begin
         n_fail++;
         $display("FAIL coincident_hit1: got %h required b2", mdt_hit_o);
      end
      pop_hit();
      n_checks++;
      if (mdt_hit_empty_o !== 1'b1 || roi_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL coincident_drained: hemp=%0b remp=%0b required 1/1", mdt_hit_empty_o, roi_empty_o);
      end
   endtask

   task automatic test_backpressure();
      send_roi(32'h0000_00F1);
      for (int i = 0; i < HIT_DEPTH; i++) send_hit(HIT_W'(100 + i), 1'b0);
      n_checks++;
      if (hit_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_full_ready: hit_ready_o=%0b required 0", hit_ready_o);
      end
      hit_i = HIT_W'(164); hit_vld_i = 1'b1;
      repeat (3) step();
      n_checks++;
      if (hit_ready_o !== 1'b0 || mdt_hit_o !== HIT_W'(100)) begin
         n_fail++;
         $display("FAIL bp_held: hit_ready_o=%0b head=%0d required 0/100", hit_ready_o, mdt_hit_o);
      end
      pop_hit();
      n_checks++;
      if (hit_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_after_read_ready: hit_ready_o=%0b required 1", hit_ready_o);
      end
      step();
      hit_vld_i = 1'b0;
      n_checks++;
      if (hit_ready_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
         n_fail++;
         $display("FAIL bp_refilled: hit_ready_o=%0b drop=%0d required 0/0", hit_ready_o, drop_cnt_o);
      end
      close_evt();
      step();
      n_checks++;
      if (histogram_accumulation_count_o !== 10'd65) begin
         n_fail++;
         $display("FAIL bp_count: got %0d required 65", histogram_accumulation_count_o);
      end
      mdt_hit_re_i = 1'b1;
      for (int i = 0; i < HIT_DEPTH; i++) begin
         n_checks++;
         if (mdt_hit_o !== HIT_W'(101 + i)) begin
            n_fail++;
            $display("FAIL bp_drain[%0d]: got %0d required %0d", i, mdt_hit_o, 101 + i);
         end
         step();
      end
      mdt_hit_re_i = 1'b0;
      pop_roi();
      n_checks++;
      if (mdt_hit_empty_o !== 1'b1 || roi_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_drained: hemp=%0b remp=%0b required 1/1", mdt_hit_empty_o, roi_empty_o);
      end
   endtask

   task automatic test_roi_full();
      for (int k = 0; k < ROI_DEPTH; k++) begin
         send_roi(ROI_W'(32'h100 + k));
         close_evt();
      end
      n_checks++;
      if (roi_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL roi_full_ready: roi_ready_o=%0b required 0", roi_ready_o);
      end
      step();
      n_checks++;
      if (roi_empty_o !== 1'b0 || roi_o !== 32'h100) begin
         n_fail++;
         $display("FAIL roi_full_head: empty=%0b roi=%h required 0/100", roi_empty_o, roi_o);
      end
      pop_roi();
      n_checks++;
      if (roi_ready_o !== 1'b1 || roi_o !== 32'h101) begin
         n_fail++;
         $display("FAIL roi_full_after_pop: ready=%0b roi=%h required 1/101", roi_ready_o, roi_o);
      end
      roi_re_i = 1'b1;
      repeat (3) step();
      roi_re_i = 1'b0;
      n_checks++;
      if (roi_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL roi_full_drained: roi_empty_o=%0b required 1", roi_empty_o);
      end
   endtask

   task automatic test_drops_saturation();
      int  sent = 0;
      int  rd   = 0;
      int  t    = 0;
      bit  closed = 1'b0;
      bit  w_ok, r_ok, cl;
      hit_i = 40'hDEAD; hit_vld_i = 1'b1;
      repeat (4) step();
      hit_vld_i = 1'b0;
      n_checks++;
      if (drop_cnt_o !== 16'd4 || cnt_sat_o !== 1'b0) begin
         n_fail++;
         $display("FAIL drops: drop=%0d sat=%0b required 4/0", drop_cnt_o, cnt_sat_o);
      end
      send_roi(32'h0000_5A7A);
      mdt_hit_re_i = 1'b1;
      for (int cyc = 0; cyc < 1500 && (rd < 1030 || !closed); cyc++) begin
         hit_vld_i   = (sent < 1030);
         hit_i       = HIT_W'(sent);
         cl          = (sent == 1030) && !closed;
         evt_close_i = cl;
         w_ok        = hit_vld_i && hit_ready_o;
         r_ok        = !mdt_hit_empty_o;
         if (r_ok) begin
            n_checks++;
            if (mdt_hit_o !== HIT_W'(rd)) begin
               n_fail++;
               $display("FAIL sat_hit[%0d]: got %0d required %0d", rd, mdt_hit_o, rd);
            end
         end
         step();
         if (w_ok) sent++;
         if (r_ok) rd++;
         if (cl) closed = 1'b1;
      end
      hit_vld_i = 1'b0; evt_close_i = 1'b0; mdt_hit_re_i = 1'b0;
      n_checks++;
      if (rd != 1030 || !closed) begin
         n_fail++;
         $display("FAIL sat_hits_read: read=%0d closed=%0b required 1030/1", rd, closed);
      end
      while (roi_empty_o && t < 10) begin
         step();
         t++;
      end
      n_checks++;
      if (roi_empty_o !== 1'b0 || histogram_accumulation_count_o !== 10'd1023 || cnt_sat_o !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_count: empty=%0b cnt=%0d sat=%0b required 0/1023/1", roi_empty_o,
                  histogram_accumulation_count_o, cnt_sat_o);
      end
      pop_roi();
      n_checks++;
      if (drop_cnt_o !== 16'd4 || mdt_hit_empty_o !== 1'b1 || roi_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_end: drop=%0d hemp=%0b remp=%0b required 4/1/1", drop_cnt_o,
                  mdt_hit_empty_o, roi_empty_o);
      end
   endtask

   task automatic test_flush();
      send_roi(32'h0000_000D);
      for (int i = 0; i < 5; i++) send_hit(HIT_W'(40'hD0 + i), 1'b0);
      srst = 1'b1;
      step();
      srst = 1'b0;
      n_checks++;
      if ({hit_ready_o, roi_ready_o, mdt_hit_empty_o, roi_empty_o} !== 4'b0011) begin
         n_fail++;
         $display("FAIL flush_flags: {hrdy,rrdy,hemp,remp}=%b required 0011",
                  {hit_ready_o, roi_ready_o, mdt_hit_empty_o, roi_empty_o});
      end
      n_checks++;
      if (drop_cnt_o !== 16'd0 || cnt_sat_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_stats: drop=%0d sat=%0b required 0/0", drop_cnt_o, cnt_sat_o);
      end
      step();
      n_checks++;
      if (roi_ready_o !== 1'b1 || roi_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_recover: rrdy=%0b remp=%0b required 1/1", roi_ready_o, roi_empty_o);
      end
      send_roi(32'h0000_000E);
      send_hit(40'hE0, 1'b1);
      step();
      n_checks++;
      if (roi_empty_o !== 1'b0 || roi_o !== 32'h0000_000E || histogram_accumulation_count_o !== 10'd1) begin
         n_fail++;
         $display("FAIL flush_roi_e: empty=%0b roi=%h cnt=%0d required 0/e/1", roi_empty_o, roi_o,
                  histogram_accumulation_count_o);
      end
      n_checks++;
      if (mdt_hit_o !== 40'hE0) begin
         n_fail++;
         $display("FAIL flush_hit_e: got %h required e0", mdt_hit_o);
      end
      pop_hit();
      pop_roi();
      n_checks++;
      if (mdt_hit_empty_o !== 1'b1 || roi_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_drained: hemp=%0b remp=%0b required 1/1", mdt_hit_empty_o, roi_empty_o);
      end
   endtask

   initial begin
      test_reset();
      test_basic_event();
      test_close_coincident();
      test_backpressure();
      test_roi_full();
      test_drops_saturation();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
